// File: rtl/hazard_ctrl_if.sv
// Hazard-controller interface: hazard inputs from ID/EX/MEM and stage-register controls.
// slave = the controller, master = the pipeline (or bench) side.
interface hazard_ctrl_if;
  logic [4:0] ID_RS1addr_i;
  logic [4:0] ID_RS2addr_i;
  logic       EX_MemRead_i;
  logic [4:0] EX_RDaddr_i;
  logic       Branch_taken_i;
  logic       MEM_access_i;
  logic       Dmem_ready_i;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFIDFlush_o;
  logic       IDEXWrite_o;
  logic       IDEXBubble_o;
  logic       EXMEMWrite_o;
  logic       MEMWBBubble_o;
  logic       Dmem_req_o;
  logic       Mem_timeout_o;
  logic       State_o;

  modport master (
    output ID_RS1addr_i, ID_RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
           Branch_taken_i, MEM_access_i, Dmem_ready_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
           EXMEMWrite_o, MEMWBBubble_o, Dmem_req_o, Mem_timeout_o, State_o
  );

  modport slave (
    input  ID_RS1addr_i, ID_RS2addr_i, EX_MemRead_i, EX_RDaddr_i,
           Branch_taken_i, MEM_access_i, Dmem_ready_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
           EXMEMWrite_o, MEMWBBubble_o, Dmem_req_o, Mem_timeout_o, State_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, dmem freeze with timeout.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hazard_ctrl_if.slave    hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] Stall_cycles_o,
  output logic [CNT_W-1:0] Flush_count_o
`endif
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             to_q, to_nx;
  logic             lu, miss;

  assign lu   = hz.EX_MemRead_i && (hz.EX_RDaddr_i != 5'd0) &&
                ((hz.EX_RDaddr_i == hz.ID_RS1addr_i) || (hz.EX_RDaddr_i == hz.ID_RS2addr_i));
  assign miss = hz.MEM_access_i && !hz.Dmem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      to_q    <= to_nx;
    end
  end

  always_comb begin
    hz.PCWrite_o     = 1'b1;
    hz.IFIDWrite_o   = 1'b1;
    hz.IFIDFlush_o   = 1'b0;
    hz.IDEXWrite_o   = 1'b1;
    hz.IDEXBubble_o  = 1'b0;
    hz.EXMEMWrite_o  = 1'b1;
    hz.MEMWBBubble_o = 1'b0;
    hz.Dmem_req_o    = hz.MEM_access_i;
    state_nx         = state_q;
    cnt_nx           = cnt_q;
    to_nx            = to_q;
    unique case (state_q)
      RUN: begin
        // A miss holds ID/EX, so LU and branch get re-resolved once the freeze lifts.
        if (miss) begin
          hz.PCWrite_o     = 1'b0;
          hz.IFIDWrite_o   = 1'b0;
          hz.IDEXWrite_o   = 1'b0;
          hz.EXMEMWrite_o  = 1'b0;
          hz.MEMWBBubble_o = 1'b1;
          state_nx         = MEM_WAIT;
          cnt_nx           = CNT_W'(1);
        end else if (lu) begin
          hz.PCWrite_o    = 1'b0;
          hz.IFIDWrite_o  = 1'b0;
          hz.IDEXBubble_o = 1'b1;
        end else if (hz.Branch_taken_i) begin
          hz.IFIDFlush_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.Dmem_ready_i) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          hz.PCWrite_o     = 1'b0;
          hz.IFIDWrite_o   = 1'b0;
          hz.IDEXWrite_o   = 1'b0;
          hz.EXMEMWrite_o  = 1'b0;
          hz.MEMWBBubble_o = 1'b1;
          if (cnt_q != '1) cnt_nx = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TIMEOUT)) to_nx = 1'b1;
        end
        // Access vanishing mid-wait is a protocol error: flag it and resume.
        if (!hz.MEM_access_i) begin
          state_nx = RUN;
          cnt_nx   = '0;
          to_nx    = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
    if (rst_i) begin
      hz.PCWrite_o     = 1'b0;
      hz.IFIDWrite_o   = 1'b0;
      hz.IFIDFlush_o   = 1'b0;
      hz.IDEXWrite_o   = 1'b0;
      hz.IDEXBubble_o  = 1'b1;
      hz.EXMEMWrite_o  = 1'b0;
      hz.MEMWBBubble_o = 1'b1;
      hz.Dmem_req_o    = 1'b0;
    end
  end

  assign hz.Mem_timeout_o = to_q;
  assign hz.State_o       = (state_q == MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      Stall_cycles_o <= '0;
      Flush_count_o  <= '0;
    end else begin
      if (!hz.PCWrite_o && Stall_cycles_o != '1) Stall_cycles_o <= Stall_cycles_o + CNT_W'(1);
      if (hz.IFIDFlush_o && Flush_count_o != '1)  Flush_count_o  <= Flush_count_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle model comparison plus literal expectations.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .hz(hif)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_cycles_o(stall_cnt), .Flush_count_o(flush_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Literal expectation for the current cycle; bits:
  // [9]PCWrite [8]IFIDWrite [7]IFIDFlush [6]IDEXWrite [5]IDEXBubble
  // [4]EXMEMWrite [3]MEMWBBubble [2]Dmem_req [1]Mem_timeout [0]State
  logic [9:0] lit_val = '0;
  string      lit_name = "";
  bit         lit_en = 0;

  // Model state: waiting flag, wait count, sticky error, perf tallies
  bit m_wait = 0;
  int m_cnt  = 0;
  bit m_to   = 0;
  int m_stall = 0;
  int m_flush = 0;

  logic [9:0] outs;
  assign outs = {hif.PCWrite_o, hif.IFIDWrite_o, hif.IFIDFlush_o, hif.IDEXWrite_o,
                 hif.IDEXBubble_o, hif.EXMEMWrite_o, hif.MEMWBBubble_o, hif.Dmem_req_o,
                 hif.Mem_timeout_o, hif.State_o};

  function automatic logic [9:0] model_out();
    bit lu, miss, frz, stl, fl;
    lu   = hif.EX_MemRead_i && hif.EX_RDaddr_i != 0 &&
           (hif.EX_RDaddr_i == hif.ID_RS1addr_i || hif.EX_RDaddr_i == hif.ID_RS2addr_i);
    miss = hif.MEM_access_i && !hif.Dmem_ready_i;
    frz  = m_wait ? !hif.Dmem_ready_i : miss;
    stl  = !m_wait && !miss && lu;
    fl   = !m_wait && !miss && !lu && hif.Branch_taken_i;
    if (rst) return {8'b00001010, m_to, m_wait};
    return {!(frz || stl), !(frz || stl), fl, !frz, stl, !frz, frz,
            hif.MEM_access_i, m_to, m_wait};
  endfunction

  always @(negedge clk) begin
    logic [9:0] exp_o;
    exp_o = model_out();
    tests++;
    if (outs !== exp_o) begin
      fails++;
      $display("FAIL model t=%0t got=%b want=%b", $time, outs, exp_o);
    end
    if (lit_en) begin
      tests++;
      if (outs !== lit_val) begin
        fails++;
        $display("FAIL %s got=%b want=%b", lit_name, outs, lit_val);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    tests++;
    if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
      fails++;
      $display("FAIL perf got=%0d/%0d want=%0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    // advance the model to the next cycle
    if (rst) begin
      m_wait = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_o[9] && m_stall < 65535) m_stall++;
      if (exp_o[7] && m_flush < 65535) m_flush++;
      if (!m_wait) begin
        if (hif.MEM_access_i && !hif.Dmem_ready_i) begin m_wait = 1; m_cnt = 1; end
      end else if (!hif.MEM_access_i) begin
        m_wait = 0; m_cnt = 0; m_to = 1;
      end else if (hif.Dmem_ready_i) begin
        m_wait = 0; m_cnt = 0;
      end else begin
        if (m_cnt == TO) m_to = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  task automatic drv(input bit r, input int rs1, input int rs2, input bit mrd,
                     input int rd, input bit br, input bit acc, input bit rdy);
    rst = r;
    hif.ID_RS1addr_i   = 5'(rs1);
    hif.ID_RS2addr_i   = 5'(rs2);
    hif.EX_MemRead_i   = mrd;
    hif.EX_RDaddr_i    = 5'(rd);
    hif.Branch_taken_i = br;
    hif.MEM_access_i   = acc;
    hif.Dmem_ready_i   = rdy;
  endtask

  // Hold current inputs one cycle, checking outputs against a literal.
  task automatic step(input string name, input logic [9:0] v);
    lit_name = name; lit_val = v; lit_en = 1;
    @(negedge clk); #1;
    lit_en = 0;
    @(posedge clk); #1;
  endtask

  localparam logic [9:0] IDLE  = 10'b1101010000;
  localparam logic [9:0] LUST  = 10'b0001110000;
  localparam logic [9:0] BRFL  = 10'b1111010000;
  localparam logic [9:0] MISS0 = 10'b0000001100;
  localparam logic [9:0] WAIT1 = 10'b0000001101;
  localparam logic [9:0] REL   = 10'b1101010101;

  initial begin
    drv(1, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    step("reset_forced", 10'b0000101000);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step("idle_after_reset", IDLE);

    // load-use then bubble clears it; rd=x0 never stalls
    drv(0, 1, 5, 1, 5, 0, 0, 0); step("lu_stall", LUST);
    drv(0, 1, 5, 0, 0, 0, 0, 0); step("lu_cleared", IDLE);
    drv(0, 0, 0, 1, 0, 0, 0, 0); step("lu_x0", IDLE);

    // branch alone, then branch deferred behind LU
    drv(0, 0, 0, 0, 0, 1, 0, 0); step("br_flush", BRFL);
    drv(0, 7, 2, 1, 7, 1, 0, 0); step("br_lu_stall", LUST);
    drv(0, 7, 2, 0, 0, 1, 0, 0); step("br_after_lu", BRFL);

    // memory wait: 3 not-ready cycles then release
    drv(0, 0, 0, 0, 0, 0, 1, 0); step("miss_run", MISS0);
    step("wait_a", WAIT1);
    step("wait_b", WAIT1);
    drv(0, 0, 0, 0, 0, 0, 1, 1); step("release", REL);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step("run_after", IDLE);

    // priority: freeze wins over LU and branch, both re-resolved afterwards
    drv(0, 3, 0, 1, 3, 1, 1, 0); step("prio_freeze", MISS0);
    drv(0, 3, 0, 1, 3, 1, 1, 1); step("prio_release", REL);
    drv(0, 3, 0, 1, 3, 1, 0, 0); step("prio_lu", LUST);
    drv(0, 3, 0, 0, 0, 1, 0, 0); step("prio_br", BRFL);

    // timeout: wait_cnt reaches 4 then error is sticky; reset mid-wait
    drv(0, 0, 0, 0, 0, 0, 1, 0); step("to_miss", MISS0);
    step("to_w1", WAIT1);
    step("to_w2", WAIT1);
    step("to_w3", WAIT1);
    step("to_w4", WAIT1);
    step("to_set", 10'b0000001111);
    step("to_sticky", 10'b0000001111);
    drv(1, 0, 0, 0, 0, 0, 1, 0); step("rst_mid_wait", 10'b0000101011);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step("to_cleared", IDLE);

    // access dropped mid-wait: error raised, back to RUN
    drv(0, 0, 0, 0, 0, 0, 1, 0); step("drop_miss", MISS0);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step("drop_wait", 10'b0000001001);
    step("drop_err", 10'b1101010010);
    drv(1, 0, 0, 0, 0, 0, 0, 0); step("final_rst", 10'b0000101010);
    drv(0, 0, 0, 0, 0, 0, 0, 0); step("final_idle", IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives write-enable, flush and bubble controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB stage registers.
- Detects load-use hazards and taken-branch redirects.
- Freezes the whole pipeline while a variable-latency data-memory access is outstanding, with timeout supervision.

Parameters:
- TIMEOUT, 255: max cycles in MEM_WAIT before timeout error; legal range 1..65535.
- CNT_W, 16: width of the wait counter and the optional performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- EX_MemRead_i  in  1  instruction in EX is a load.
- EX_RDaddr_i  in  5  rd of the instruction in EX.
- Branch_taken_i  in  1  branch/jump in ID resolved taken.
- MEM_access_i  in  1  instruction in MEM is a load or store.
- Dmem_ready_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF_ID load enable.
- IFIDFlush_o  out  1  IF_ID loads a NOP.
- IDEXWrite_o  out  1  ID_EX load enable.
- IDEXBubble_o  out  1  zero RegWrite/MemtoReg/MemRead/MemWrite into ID_EX.
- EXMEMWrite_o  out  1  EX_MEM load enable.
- MEMWBBubble_o  out  1  MEM_WB loads a bubble (RegWrite=0).
- Dmem_req_o  out  1  data-memory request.
- Mem_timeout_o  out  1  sticky timeout error flag.
- State_o  out  1  0=RUN, 1=MEM_WAIT.

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset:
  - While rst_i=1, combinational outputs are forced: PCWrite_o=IFIDWrite_o=IDEXWrite_o=EXMEMWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=1, MEMWBBubble_o=1, Dmem_req_o=0.
  - On a clock edge with rst_i=1: state<=RUN, wait_cnt<=0, Mem_timeout_o<=0.
  - After rst_i deasserts, the first cycle is RUN.
- Outputs: Mealy, combinational from state and inputs, and take effect in the same cycle.
- Defaults: all write enables 1, flush/bubble 0.
- Dmem_req_o = MEM_access_i, in both states.
- Hazard terms:
  - LU = EX_MemRead_i & (EX_RDaddr_i != 0) & (EX_RDaddr_i == ID_RS1addr_i | EX_RDaddr_i == ID_RS2addr_i).
  - MISS = MEM_access_i & ~Dmem_ready_i.
- Priority in RUN is MISS > LU > Branch_taken_i:
  - MISS: freeze. PCWrite_o, IFIDWrite_o, IDEXWrite_o and EXMEMWrite_o are 0; MEMWBBubble_o=1. Next state MEM_WAIT, wait_cnt<=1. LU and branch are ignored this cycle and re-evaluated after the freeze, because the ID/EX contents are held.
  - LU, no MISS: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. This is exactly one bubble; the next cycle EX holds the bubble, so LU clears. A Branch_taken_i in the same cycle is deferred: the branch stays in ID and is re-resolved next cycle.
  - Branch_taken_i alone: IFIDFlush_o=1, PC loads the target (PCWrite_o=1). This is a 1-cycle penalty.
- MEM_WAIT:
  - Freeze outputs identical to the RUN MISS case.
  - If Dmem_ready_i=1: that cycle releases (all enables 1, MEMWBBubble_o=0), and the next state is RUN with wait_cnt<=0. LU and branch are not evaluated in the release cycle.
  - Otherwise wait_cnt increments, saturating at 2^CNT_W-1.
  - When wait_cnt==TIMEOUT and not ready: Mem_timeout_o<=1 (sticky until reset). The state stays MEM_WAIT, so the pipeline remains frozen.
  - If MEM_access_i drops in MEM_WAIT (illegal), return to RUN next cycle and set Mem_timeout_o.
- Reset mid-MEM_WAIT: next cycle is RUN, counters cleared; the outstanding access is abandoned.
- rd=x0 never causes a load-use stall.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_cycles_o [CNT_W-1:0] and Flush_count_o [CNT_W-1:0], both reset to 0 and saturating.
  - Stall_cycles_o increments on each cycle with PCWrite_o=0.
  - Flush_count_o increments on each cycle with IFIDFlush_o=1.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Load-use: EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 -> exactly 1 cycle with PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1; with EX_RDaddr_i=0 -> no stall.
2. Branch: Branch_taken_i=1, no hazards -> IFIDFlush_o=1, PCWrite_o=1 for 1 cycle. Branch_taken_i together with LU -> stall first, flush in the following cycle.
3. Memory wait: MEM_access_i=1, Dmem_ready_i low 3 cycles then high -> State_o=1 for 3 cycles, all enables 0 and MEMWBBubble_o=1, release on the 4th cycle, RUN after.
4. Timeout: TIMEOUT=4, Dmem_ready_i held 0 -> Mem_timeout_o rises after wait_cnt reaches 4 and stays 1. rst_i=1 one cycle -> Mem_timeout_o=0, State_o=0.
5. Reset behaviour: rst_i=1 mid-MEM_WAIT -> forced reset outputs that cycle, RUN next.
6. Priority: MISS with simultaneous LU and Branch_taken_i -> only the freeze applies. With HAZARD_PERF_CNT_EN, Stall_cycles_o matches the number of stall cycles counted by the bench.
